nc_predictor_param: RTL and testbench
=====================================

// Module: nc_predictor_param
// PURPOSE
//  CAVLC nC predictor, next generation of the fixed 4:2:0 nC decoder. It keeps its own neighbour
//  TotalCoeff store: current-MB registers, a left-column register set and a top-row line buffer.
//  It serves luma, Cb AC, Cr AC and chroma-DC requests over a req/valid handshake.
//  Sits between the CAVLC control FSM and coeff_token table select; picture width is a parameter.
// PARAMETERS
//  MB_W_MAX   120  max macroblocks per row (line-buffer depth)
//  MBW         7   width of MB coordinates, ceil(log2(MB_W_MAX))
//  TC_W        5   TotalCoeff / nC width
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous active-low reset
//  mb_num_h     in   MBW    current MB column
//  mb_num_v     in   MBW    current MB row
//  mb_avail_a   in   1      left MB available (slice-aware)
//  mb_avail_b   in   1      top MB available (slice-aware)
//  nc_req       in   1      lookup request (1-cycle pulse)
//  req_type     in   2      0 luma, 1 Cb AC, 2 Cr AC, 3 chroma DC
//  req_idx      in   4      block index: luma 0..15 zigzag, chroma 0..3
//  tc_we        in   1      write TotalCoeff of a just-decoded block
//  tc_type      in   2      component of write (0..2)
//  tc_idx       in   4      block index of write
//  tc_val       in   TC_W   TotalCoeff 0..16
//  mb_end       in   1      commit current MB to neighbour stores
//  mb_fill16    in   1      with mb_end: I_PCM, commit all 16
//  mb_clr       in   1      with mb_end: skip MB, commit all 0
//  busy         out  1      lookup in flight
//  nc_valid     out  1      nc valid (1-cycle pulse)
//  nc           out  TC_W   predicted nC; 5'b11111 means -1 (chroma DC)
// BEHAVIOUR
//  Reset
//  - State IDLE; busy=0, nc_valid=0, nc=0.
//  - Current/left registers clear to 0. Line buffer is not cleared; row 0 never reads it.
//  FSM: IDLE -> RD_A -> RD_B -> CALC -> IDLE.
//  - nc_req in IDLE is accepted.
//  - nc_valid and nc are registered in CALC; nc_valid rises 3 cycles after the req edge.
//  - busy=1 from RD_A through CALC. nc_req while busy is ignored (no queueing).
//  - req_type=3 returns nc=5'b11111 with the same 3-cycle latency; no store access.
//  Block geometry
//  - Luma: x={idx[2],idx[0]}, y={idx[3],idx[1]}.
//  - Chroma: x=idx[0], y=idx[1].
//  Neighbour A
//  - x>0: current MB [x-1,y].
//  - x=0: left register [y]; available iff mb_avail_a && mb_num_h!=0.
//  Neighbour B
//  - y>0: current MB [x,y-1].
//  - y=0: line buffer[mb_num_h] entry x; available iff mb_avail_b && mb_num_v!=0.
//  - Line-buffer read is issued in RD_A; data is used in RD_B (1-cycle sync RAM).
//  nC = (nA+nB+1)>>1 if both available; the available one's value if one; 0 if none.
//  - Sum is computed in TC_W+1 bits; max is 16, no overflow.
//  Stores and commit
//  - tc_we writes current-MB registers on the edge.
//  - tc_we in the same cycle as nc_req is visible to that request (write-before-lookup).
//  - mb_end commits on its edge:
//    - Bottom row (luma y=3, chroma y=1) goes to line buffer[mb_num_h]: 8 x TC_W bits.
//    - Right column goes to the left registers.
//    - Current registers then clear to 0.
//  - mb_fill16 / mb_clr override committed values with 16 / 0; if both are set, mb_clr wins.
//  - mb_end while busy aborts the lookup: nc_valid is not pulsed and the FSM returns to IDLE.
//  - Line-buffer same-address read and write in one cycle returns old data.
//  - Reset mid-lookup: FSM returns to IDLE immediately; no nc_valid is pulsed.
// STRUCTURE
//  - Package h264_nc_pkg:
//    - blk_type_t enum (LUMA, CB, CR, CDC).
//    - NC_MINUS1 = 5'b11111.
//    - Function zz2xy().
//  - Sub-module nc_top_line_ram: MB_W_MAX x (8*TC_W) single-port sync RAM, read-old-data.
//  - FSM, current/left register files and the averaging arithmetic stay in this module.
// TESTING
//  1 MB(0,0), luma idx 0, req -> nc_valid on cycle 3, nc=0; busy high cycles 1..3.
//  2 Write luma idx1=7, idx2=4; req idx3 -> nc=(4+7+1)>>1=6.
//  3 MB(2,0) TCs committed at mb_end; at MB(2,1), mb_avail_b=1, req luma idx 0, left=0, avail_a=0 -> nc = top[0].
//  4 I_PCM MB committed with mb_fill16; next MB's luma idx 0 with only A available -> nc=16.
//  5 req_type=3 -> nc=5'b11111. Back-to-back nc_req while busy is ignored: exactly one nc_valid.
//  6 Reset asserted during RD_B -> busy=0, no nc_valid. After release, req at MB(0,0) -> nc=0.

Source files
------------

// File: rtl/h264_nc_pkg.sv
// rtl/h264_nc_pkg.sv - shared types, constants and block-geometry helper for the nC predictor
package h264_nc_pkg;

   typedef enum logic [1:0] {
      BLK_LUMA = 2'd0,
      BLK_CB   = 2'd1,
      BLK_CR   = 2'd2,
      BLK_CDC  = 2'd3
   } blk_type_t;

   typedef enum logic [1:0] {
      NC_IDLE = 2'd0,
      NC_RD_A = 2'd1,
      NC_RD_B = 2'd2,
      NC_CALC = 2'd3
   } nc_state_t;

   localparam logic [4:0] NC_MINUS1 = 5'b11111;

   // Returns {y[1:0], x[1:0]}; chroma only uses bit 0 of each coordinate.
   function automatic logic [3:0] zz2xy(input logic [3:0] idx, input logic is_luma);
      logic [1:0] x;
      logic [1:0] y;
      if (is_luma) begin
         x = {idx[2], idx[0]};
         y = {idx[3], idx[1]};
      end else begin
         x = {1'b0, idx[0]};
         y = {1'b0, idx[1]};
      end
      return {y, x};
   endfunction

endpackage

// File: rtl/nc_top_line_ram.sv
// rtl/nc_top_line_ram.sv - single-port synchronous line buffer holding each MB's bottom-row TotalCoeffs
module nc_top_line_ram #(
   parameter int DEPTH = 120,
   parameter int AW    = 7,
   parameter int DW    = 40
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Read samples the array before this edge's write lands, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/nc_predictor_param.sv
// rtl/nc_predictor_param.sv - CAVLC nC predictor with its own current/left/top TotalCoeff stores
module nc_predictor_param
   import h264_nc_pkg::*;
#(
   parameter int MB_W_MAX = 120,
   parameter int MBW      = 7,
   parameter int TC_W     = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [MBW-1:0]  mb_num_h,
   input  logic [MBW-1:0]  mb_num_v,
   input  logic            mb_avail_a,
   input  logic            mb_avail_b,
   input  logic            nc_req,
   input  logic [1:0]      req_type,
   input  logic [3:0]      req_idx,
   input  logic            tc_we,
   input  logic [1:0]      tc_type,
   input  logic [3:0]      tc_idx,
   input  logic [TC_W-1:0] tc_val,
   input  logic            mb_end,
   input  logic            mb_fill16,
   input  logic            mb_clr,
   output logic            busy,
   output logic            nc_valid,
   output logic [TC_W-1:0] nc
);

   localparam int LINE_W = 8 * TC_W;

   nc_state_t state, state_nxt;
   blk_type_t req_kind_q;
   logic [3:0] pos_q;

   logic [TC_W-1:0] cur_luma  [16];
   logic [TC_W-1:0] cur_cb    [4];
   logic [TC_W-1:0] cur_cr    [4];
   logic [TC_W-1:0] left_luma [4];
   logic [TC_W-1:0] left_cb   [2];
   logic [TC_W-1:0] left_cr   [2];

   logic [TC_W-1:0]   na_val, nb_val, na_q;
   logic              na_av, nb_av, na_av_q;
   logic              left_ok, top_ok, line_re;
   logic [LINE_W-1:0] line_wdata, line_rdata;
   logic [1:0]        bx, by, bx_m1, by_m1;
   logic [3:0]        wpos;
   logic [TC_W:0]     sum;

   assign bx      = pos_q[1:0];
   assign by      = pos_q[3:2];
   assign bx_m1   = bx - 2'd1;
   assign by_m1   = by - 2'd1;
   assign left_ok = mb_avail_a && (mb_num_h != '0);
   assign top_ok  = mb_avail_b && (mb_num_v != '0);
   assign busy    = (state != NC_IDLE);
   assign line_re = (state == NC_RD_A) && (req_kind_q != BLK_CDC);
   assign wpos    = zz2xy(tc_idx, tc_type == 2'd0);

   function automatic logic [TC_W-1:0] commit_val(input logic [TC_W-1:0] v,
                                                  input logic fill, input logic clr);
      if (clr) return '0;
      if (fill) return TC_W'(16);
      return v;
   endfunction

   nc_top_line_ram #(
      .DEPTH (MB_W_MAX),
      .AW    (MBW),
      .DW    (LINE_W)
   ) u_line_ram (
      .clk   (clk),
      .we    (mb_end),
      .re    (line_re),
      .addr  (mb_num_h),
      .wdata (line_wdata),
      .rdata (line_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= NC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // mb_end pre-empts any lookup: the stores change under it, so its result would be stale.
   always_comb begin
      state_nxt = state;
      case (state)
         NC_IDLE: if (nc_req && !mb_end) state_nxt = NC_RD_A;
         NC_RD_A: state_nxt = mb_end ? NC_IDLE : NC_RD_B;
         NC_RD_B: state_nxt = mb_end ? NC_IDLE : NC_CALC;
         default: state_nxt = NC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_kind_q <= BLK_LUMA;
         pos_q      <= '0;
         na_q       <= '0;
         na_av_q    <= 1'b0;
      end else begin
         if (state == NC_IDLE && nc_req) begin
            req_kind_q <= blk_type_t'(req_type);
            pos_q      <= zz2xy(req_idx, req_type == 2'd0);
         end
         if (state == NC_RD_A) begin
            na_q    <= na_val;
            na_av_q <= na_av;
         end
      end
   end

   always_comb begin
      na_val = '0;
      na_av  = 1'b0;
      case (req_kind_q)
         BLK_LUMA: begin
            if (bx != 2'd0) begin
               na_val = cur_luma[{by, bx_m1}];
               na_av  = 1'b1;
            end else begin
               na_val = left_luma[by];
               na_av  = left_ok;
            end
         end
         BLK_CB: begin
            na_val = bx[0] ? cur_cb[{by[0], 1'b0}] : left_cb[by[0]];
            na_av  = bx[0] | left_ok;
         end
         BLK_CR: begin
            na_val = bx[0] ? cur_cr[{by[0], 1'b0}] : left_cr[by[0]];
            na_av  = bx[0] | left_ok;
         end
         default: ;
      endcase
   end

   // Top-row entries: luma x at 0..3, Cb x at 4..5, Cr x at 6..7.
   always_comb begin
      logic [2:0] ent;
      nb_val = '0;
      nb_av  = 1'b0;
      ent    = '0;
      case (req_kind_q)
         BLK_LUMA: ent = {1'b0, bx};
         BLK_CB:   ent = {2'b10, bx[0]};
         BLK_CR:   ent = {2'b11, bx[0]};
         default:  ent = '0;
      endcase
      case (req_kind_q)
         BLK_LUMA: begin
            if (by != 2'd0) begin
               nb_val = cur_luma[{by_m1, bx}];
               nb_av  = 1'b1;
            end else begin
               nb_val = line_rdata[int'(ent)*TC_W +: TC_W];
               nb_av  = top_ok;
            end
         end
         BLK_CB: begin
            nb_val = by[0] ? cur_cb[{1'b0, bx[0]}] : line_rdata[int'(ent)*TC_W +: TC_W];
            nb_av  = by[0] | top_ok;
         end
         BLK_CR: begin
            nb_val = by[0] ? cur_cr[{1'b0, bx[0]}] : line_rdata[int'(ent)*TC_W +: TC_W];
            nb_av  = by[0] | top_ok;
         end
         default: ;
      endcase
   end

   assign sum = {1'b0, na_q} + {1'b0, nb_val} + (TC_W+1)'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nc_valid <= 1'b0;
         nc       <= '0;
      end else begin
         nc_valid <= 1'b0;
         if (state == NC_RD_B && !mb_end) begin
            nc_valid <= 1'b1;
            if (req_kind_q == BLK_CDC)  nc <= TC_W'(NC_MINUS1);
            else if (na_av_q && nb_av)  nc <= sum[TC_W:1];
            else if (na_av_q)           nc <= na_q;
            else if (nb_av)             nc <= nb_val;
            else                        nc <= '0;
         end
      end
   end

   always_comb begin
      line_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         line_wdata[i*TC_W +: TC_W] = commit_val(cur_luma[12+i], mb_fill16, mb_clr);
      end
      for (int i = 0; i < 2; i++) begin
         line_wdata[(4+i)*TC_W +: TC_W] = commit_val(cur_cb[2+i], mb_fill16, mb_clr);
         line_wdata[(6+i)*TC_W +: TC_W] = commit_val(cur_cr[2+i], mb_fill16, mb_clr);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) cur_luma[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            cur_cb[i]    <= '0;
            cur_cr[i]    <= '0;
            left_luma[i] <= '0;
         end
         for (int i = 0; i < 2; i++) begin
            left_cb[i] <= '0;
            left_cr[i] <= '0;
         end
      end else if (mb_end) begin
         for (int i = 0; i < 4; i++) begin
            left_luma[i] <= commit_val(cur_luma[4*i+3], mb_fill16, mb_clr);
         end
         for (int i = 0; i < 2; i++) begin
            left_cb[i] <= commit_val(cur_cb[2*i+1], mb_fill16, mb_clr);
            left_cr[i] <= commit_val(cur_cr[2*i+1], mb_fill16, mb_clr);
         end
         for (int i = 0; i < 16; i++) cur_luma[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            cur_cb[i] <= '0;
            cur_cr[i] <= '0;
         end
      end else if (tc_we) begin
         case (tc_type)
            2'd0:    cur_luma[wpos]            <= tc_val;
            2'd1:    cur_cb[{wpos[2], wpos[0]}] <= tc_val;
            2'd2:    cur_cr[{wpos[2], wpos[0]}] <= tc_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nc_predictor_param.sv
// tb/tb_nc_predictor_param.sv - scoreboard bench for nc_predictor_param
module tb_nc_predictor_param;

   localparam int MB_W_MAX = 120;
   localparam int MBW      = 7;
   localparam int TC_W     = 5;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [MBW-1:0]  mb_num_h, mb_num_v;
   logic            mb_avail_a, mb_avail_b;
   logic            nc_req;
   logic [1:0]      req_type;
   logic [3:0]      req_idx;
   logic            tc_we;
   logic [1:0]      tc_type;
   logic [3:0]      tc_idx;
   logic [TC_W-1:0] tc_val;
   logic            mb_end, mb_fill16, mb_clr;
   logic            busy, nc_valid;
   logic [TC_W-1:0] nc;

   int n_chk   = 0;
   int n_pass  = 0;
   int n_valid = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   nc_predictor_param #(
      .MB_W_MAX (MB_W_MAX),
      .MBW      (MBW),
      .TC_W     (TC_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mb_num_h   (mb_num_h),
      .mb_num_v   (mb_num_v),
      .mb_avail_a (mb_avail_a),
      .mb_avail_b (mb_avail_b),
      .nc_req     (nc_req),
      .req_type   (req_type),
      .req_idx    (req_idx),
      .tc_we      (tc_we),
      .tc_type    (tc_type),
      .tc_idx     (tc_idx),
      .tc_val     (tc_val),
      .mb_end     (mb_end),
      .mb_fill16  (mb_fill16),
      .mb_clr     (mb_clr),
      .busy       (busy),
      .nc_valid   (nc_valid),
      .nc         (nc)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (nc_valid) begin
         n_valid++;
         if (exp_q.size() == 0) check_val("spurious_valid", 1, 0);
         else check_val("nc", int'(nc), exp_q.pop_front());
      end
   end

   task automatic set_mb(input int h, input int v, input logic a, input logic b);
      mb_num_h = MBW'(h);
      mb_num_v = MBW'(v);
      mb_avail_a = a;
      mb_avail_b = b;
   endtask

   task automatic wr_tc(input logic [1:0] t, input logic [3:0] i, input int val);
      tc_we = 1'b1; tc_type = t; tc_idx = i; tc_val = TC_W'(val);
      @(posedge clk); #1;
      tc_we = 1'b0;
   endtask

   task automatic commit(input logic fill, input logic clr);
      mb_end = 1'b1; mb_fill16 = fill; mb_clr = clr;
      @(posedge clk); #1;
      mb_end = 1'b0; mb_fill16 = 1'b0; mb_clr = 1'b0;
   endtask

   task automatic do_req(input logic [1:0] t, input logic [3:0] i, input int exp, input bit chk_busy);
      int lat;
      lat = 0;
      req_type = t; req_idx = i; nc_req = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      nc_req = 1'b0; tc_we = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (chk_busy) check_val("busy_in_flight", int'(busy), 1);
      end while (!nc_valid && lat < 8);
      check_val("latency", lat, 3);
      @(posedge clk); #1;
   endtask

   initial begin
      int v0;
      reset_n = 1'b0; nc_req = 1'b0; req_type = '0; req_idx = '0;
      tc_we = 1'b0; tc_type = '0; tc_idx = '0; tc_val = '0;
      mb_end = 1'b0; mb_fill16 = 1'b0; mb_clr = 1'b0;
      set_mb(0, 0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_valid", int'(nc_valid), 0);
      check_val("rst_nc", int'(nc), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      do_req(2'd0, 4'd0, 0, 1'b1);
      wr_tc(2'd0, 4'd1, 7);
      wr_tc(2'd0, 4'd2, 4);
      do_req(2'd0, 4'd3, 6, 1'b0);
      tc_we = 1'b1; tc_type = 2'd0; tc_idx = 4'd6; tc_val = TC_W'(9);
      do_req(2'd0, 4'd7, 5, 1'b0);
      wr_tc(2'd1, 4'd0, 3);
      do_req(2'd1, 4'd1, 3, 1'b0);
      wr_tc(2'd2, 4'd0, 10);
      do_req(2'd2, 4'd2, 10, 1'b0);
      do_req(2'd3, 4'd5, 31, 1'b0);

      v0 = n_valid;
      req_type = 2'd3; nc_req = 1'b1;
      exp_q.push_back(31);
      repeat (3) @(posedge clk);
      #1 nc_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("busy_req_ignored", n_valid - v0, 1);
      commit(1'b0, 1'b1);

      set_mb(2, 0, 1'b0, 1'b0);
      wr_tc(2'd0, 4'd10, 5);
      wr_tc(2'd0, 4'd11, 8);
      wr_tc(2'd1, 4'd2, 6);
      commit(1'b0, 1'b0);
      set_mb(2, 1, 1'b0, 1'b1);
      do_req(2'd0, 4'd0, 5, 1'b0);
      do_req(2'd0, 4'd1, 4, 1'b0);
      do_req(2'd1, 4'd0, 6, 1'b0);
      set_mb(2, 1, 1'b0, 1'b0);
      do_req(2'd0, 4'd0, 0, 1'b0);

      commit(1'b1, 1'b0);
      set_mb(3, 1, 1'b1, 1'b0);
      do_req(2'd0, 4'd0, 16, 1'b0);
      do_req(2'd2, 4'd0, 16, 1'b0);
      commit(1'b1, 1'b1);
      set_mb(4, 1, 1'b1, 1'b0);
      do_req(2'd0, 4'd0, 0, 1'b0);
      set_mb(2, 2, 1'b0, 1'b1);
      do_req(2'd0, 4'd0, 16, 1'b0);
      do_req(2'd2, 4'd1, 8, 1'b0);
      commit(1'b1, 1'b0);
      set_mb(5, 2, 1'b1, 1'b0);
      do_req(2'd0, 4'd0, 16, 1'b0);
      set_mb(0, 2, 1'b1, 1'b0);
      do_req(2'd0, 4'd0, 0, 1'b0);
      set_mb(2, 0, 1'b0, 1'b1);
      do_req(2'd0, 4'd0, 0, 1'b0);

      v0 = n_valid;
      req_type = 2'd0; req_idx = 4'd0; nc_req = 1'b1;
      @(posedge clk); #1;
      nc_req = 1'b0;
      mb_end = 1'b1; mb_clr = 1'b1;
      @(posedge clk); #1;
      mb_end = 1'b0; mb_clr = 1'b0;
      check_val("abort_busy", int'(busy), 0);
      repeat (4) @(posedge clk);
      #1;
      check_val("abort_no_valid", n_valid - v0, 0);

      v0 = n_valid;
      nc_req = 1'b1;
      @(posedge clk); #1;
      nc_req = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_valid", int'(nc_valid), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("midrst_no_valid", n_valid - v0, 0);
      set_mb(0, 0, 1'b0, 1'b0);
      do_req(2'd0, 4'd0, 0, 1'b0);

      check_val("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
